freelist: RTL and testbench
===========================

# freelist

Physical-register free list for the R10K-style rename pipeline. It holds one free/allocated bit per physical register and grants up to N free tags per cycle to rename/dispatch. It reclaims the `free_mask` bitmap driven by `stage_retire` (each committed lane's Told). On a branch-mispredict recovery pulse it rebuilds its state from the architected map's in-use set.

## Interface
- `N`, default `` `N ``, rename/retire width (lane N-1 = oldest).
- `ARCH_COUNT`, default 32, architectural registers; PRs 0..ARCH_COUNT-1 hold the reset mappings.
- `PHYS_REGS`, default `` `PHYS_REG_SZ_R10K ``, physical register count.
- `PRW`, localparam, `$clog2(PHYS_REGS)` (1 when PHYS_REGS <= 2).

Ports:
- `clock`  in  1  single clock for the block.
- `reset`  in  1  asynchronous, active-high.
- `alloc_req`  in  N  per-lane request for a new destination PR.
- `alloc_grant`  out  N  per-lane grant; lane w's tag is valid only when `alloc_grant[w]`.
- `alloc_tags`  out  N×PHYS_TAG  granted tags; zero for ungranted lanes.
- `free_mask`  in  PHYS_REGS  PRs returned by retire this cycle.
- `recover_en`  in  1  one-cycle recovery pulse (`bp_recover_en` from retire).
- `arch_used_mask`  in  PHYS_REGS  PRs referenced by the architected map; sampled only when `recover_en` = 1.
- `free_count`  out  PRW+1  number of free PRs in the current state.
- `double_free`  out  1  registered sticky error: a freed PR was already free.

## Operation
- State: `free_bits[PHYS_REGS-1:0]`, where 1 = free. PR0 is permanently reserved.
  - Bit 0 is always 0.
  - `free_mask[0]` is ignored.
  - PR0 is never granted.
- Grant selection (combinational from registered `free_bits`):
  - Requesting lanes are served in order N-1 down to 0.
  - Each served lane takes the lowest-indexed free PR not already taken by an older lane.
  - Lanes beyond the available supply get `alloc_grant` = 0. A younger lane may not be granted while an older requesting lane is denied.
  - Non-requesting lanes get grant 0 and tag 0.
- Normal next state: `free_bits` is cleared for every granted tag, then ORed with `free_mask` (bit 0 forced to 0).
- Recovery:
  - When `recover_en` = 1, next `free_bits` = ~`arch_used_mask`, with bit 0 forced to 0.
  - In that cycle, all `alloc_grant` outputs are 0 and `free_mask` is ignored. Retire blocks normal commit in a recover cycle, so `free_mask` is 0 anyway.
- `double_free` is set when `free_mask[i]` = 1 while `free_bits[i]` = 1 (for i ≠ 0, and not in a recover cycle). It clears only on reset.
- `free_count` = popcount(`free_bits`). It is held in a register updated alongside `free_bits`, not recomputed combinationally.

## Timing
- Reset (async assert, released on a clock edge):
  - `free_bits` = 1 for PRs ARCH_COUNT..PHYS_REGS-1, 0 for all others.
  - `free_count` = PHYS_REGS − ARCH_COUNT.
  - `double_free` = 0.
  - `alloc_grant` = 0 while reset is asserted.
- Allocation latency is 0 cycles: the grant and tag are valid in the same cycle as the request. The tag leaves the free set at the next posedge.
- A free takes effect at the next posedge. A PR freed in cycle t is grantable no earlier than cycle t+1; there is no same-cycle bypass.
- Recovery state is visible in cycle t+1 after the pulse in cycle t.
- Simultaneous events:
  - Alloc and free of different PRs in one cycle both apply.
  - Recover overrides both alloc and free.
- Empty case: with `free_count` = 0, all grants are 0 and the state is held.
- Full case: all non-zero PRs free is legal. A further free of a PR that is already free sets `double_free` and leaves the bit at 1.
- Reset asserted mid-cycle clears the state immediately. Any grant in flight is void.

## Structure
- `PHYS_TAG` and `` `PHYS_REG_SZ_R10K `` come from `sys_defs.svh`. No new shared typedefs.
- One sub-module, `freelist_psel`, parameterised by width and N:
  - Returns N one-hot vectors selecting the lowest set bits in priority order.
  - Also returns a per-output valid bit.
  - The top level encodes the one-hot vectors to tags and handles lane-to-grant ordering.

## Test plan
Bench configuration: N=3, ARCH_COUNT=32, PHYS_REGS=64.
- **Reset:** `free_count` = 32, `double_free` = 0. `alloc_req`=3'b111 → tags {lane2=32, lane1=33, lane0=34}, all granted. Next cycle `free_count` = 29.
- **Partial request:** `alloc_req`=3'b101 after reset → lane2=32, lane0=33, lane1 grant=0 with tag 0.
- **Exhaust:** drain all 32 PRs, then `alloc_req`=3'b111 → no grants, state held. Free PR 40 in cycle t → lane2 granted 40 in t+1, not in t.
- **Double free:** free PR 50 while PR 50 is free → `double_free`=1 next cycle, still 1 after 10 idle cycles. `free_mask[0]`=1 → no effect.
- **Recovery:** after allocating PRs 32..40, pulse `recover_en` with `arch_used_mask` = bits 0..31 plus 35 set, and `alloc_req`=3'b111 in the same cycle → no grants that cycle. Next cycle `free_count` = 31 and first grant = 32.
- **Mid-operation reset:** assert `reset` asynchronously between edges while requests are active → grants drop immediately. After release, state equals the reset state.

Source files
------------

// File: rtl/freelist_pkg.sv
// Shared sizing defaults and helpers for the physical-register free list.
// Tags are PRW bits wide; PRW is derived from the physical register count.
package freelist_pkg;

  localparam int FL_N          = 3;
  localparam int FL_ARCH_COUNT = 32;
  localparam int FL_PHYS_REGS  = 64;

  // Tag width for a given register count, never narrower than one bit.
  function automatic int fl_tag_width(input int phys_regs);
    return (phys_regs <= 2) ? 1 : $clog2(phys_regs);
  endfunction

endpackage

// File: rtl/freelist_psel.sv
// Multi-pick priority selector: returns N one-hot vectors naming the N lowest
// set bits of 'avail' (pick 0 = lowest), each with a valid flag.
module freelist_psel
  import freelist_pkg::*;
#(
  parameter int WIDTH = FL_PHYS_REGS,
  parameter int N     = FL_N
) (
  input  logic [WIDTH-1:0]        avail,
  output logic [N-1:0][WIDTH-1:0] pick_oh,
  output logic [N-1:0]            pick_valid
);

  logic [WIDTH-1:0] remaining;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    remaining  = avail;
    pick_oh    = '0;
    pick_valid = '0;
    // NOTE: blocking assignments on purpose: each pick must see the bits taken by earlier picks.
    for (int k = 0; k < N; k++) begin
      pick_oh[k]    = remaining & (~remaining + WIDTH'(1));
      pick_valid[k] = |remaining;
      remaining     = remaining & ~pick_oh[k];
    end
  end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: grants up to N free tags per cycle (oldest lane
// first), reclaims retired tags, and rebuilds from the architected map on recovery.
module freelist
  import freelist_pkg::*;
#(
  parameter int N          = FL_N,
  parameter int ARCH_COUNT = FL_ARCH_COUNT,
  parameter int PHYS_REGS  = FL_PHYS_REGS,
  localparam int PRW       = fl_tag_width(PHYS_REGS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N-1:0]            alloc_req,
  output logic [N-1:0]            alloc_grant,
  output logic [N-1:0][PRW-1:0]   alloc_tags,
  input  logic [PHYS_REGS-1:0]    free_mask,
  input  logic                    recover_en,
  input  logic [PHYS_REGS-1:0]    arch_used_mask,
  output logic [PRW:0]            free_count,
  output logic                    double_free
);

  localparam logic [PHYS_REGS-1:0] RESET_BITS   = {PHYS_REGS{1'b1}} << ARCH_COUNT;
  localparam logic [PRW:0]         RESET_COUNT  = (PRW+1)'(PHYS_REGS - ARCH_COUNT);
  localparam logic [PHYS_REGS-1:0] NONZERO_MASK = ~(PHYS_REGS'(1));

  logic [PHYS_REGS-1:0]        free_bits_q, free_bits_d;
  logic [PRW:0]                free_count_q, free_count_d;
  logic                        double_free_q, double_free_d;

  logic [N-1:0][PHYS_REGS-1:0] pick_oh;
  logic [N-1:0]                pick_valid;
  logic [N-1:0][PRW-1:0]       pick_tag;
  logic [PHYS_REGS-1:0]        granted_mask;
  int                          rank;

  // PR0 is never set in free_bits, so it can never be picked.
  freelist_psel #(
    .WIDTH (PHYS_REGS),
    .N     (N)
  ) u_psel (
    .avail      (free_bits_q),
    .pick_oh    (pick_oh),
    .pick_valid (pick_valid)
  );

  always_comb begin
    pick_tag = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        if (pick_oh[k][i]) pick_tag[k] = pick_tag[k] | PRW'(i);
      end
    end
  end

  // The r-th requesting lane, counted from the oldest, takes pick r. Picks run
  // out monotonically, so a younger lane is never served past a denied older one.
  always_comb begin
    alloc_grant  = '0;
    alloc_tags   = '0;
    granted_mask = '0;
    rank         = 0;
    for (int w = N - 1; w >= 0; w--) begin
      if (alloc_req[w] && !recover_en && !reset) begin
        for (int k = 0; k < N; k++) begin
          if (k == rank && pick_valid[k]) begin
            alloc_grant[w] = 1'b1;
            alloc_tags[w]  = pick_tag[k];
            granted_mask   = granted_mask | pick_oh[k];
          end
        end
        rank = rank + 1;
      end
    end
  end

  always_comb begin
    if (recover_en) begin
      free_bits_d = ~arch_used_mask;
    end else begin
      free_bits_d = (free_bits_q & ~granted_mask) | free_mask;
    end
    free_bits_d[0] = 1'b0;

    double_free_d = double_free_q | (~recover_en & (|(free_mask & free_bits_q & NONZERO_MASK)));

    // Count is taken from the next state so the registered value tracks free_bits_q.
    free_count_d = '0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      free_count_d = free_count_d + {{PRW{1'b0}}, free_bits_d[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (reset) begin
      free_bits_q   <= RESET_BITS;
      free_count_q  <= RESET_COUNT;
      double_free_q <= 1'b0;
    end else begin
      free_bits_q   <= free_bits_d;
      free_count_q  <= free_count_d;
      double_free_q <= double_free_d;
    end
  end

  assign free_count  = free_count_q;
  assign double_free = double_free_q;

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a set-based model.
module tb_freelist;

  localparam int N    = 3;
  localparam int ARCH = 32;
  localparam int PHYS = 64;
  localparam int PRW  = 6;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [N-1:0]         alloc_req = '0;
  logic [N-1:0]         alloc_grant;
  logic [N-1:0][PRW-1:0] alloc_tags;
  logic [PHYS-1:0]      free_mask = '0;
  logic                 recover_en = 1'b0;
  logic [PHYS-1:0]      arch_used_mask = '0;
  logic [PRW:0]         free_count;
  logic                 double_free;

  int checks = 0;
  int errors = 0;

  // Model: one "is free" flag per physical register plus the sticky error flag.
  bit mfree [PHYS];
  bit mdbl;

  freelist #(
    .N          (N),
    .ARCH_COUNT (ARCH),
    .PHYS_REGS  (PHYS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_grant    (alloc_grant),
    .alloc_tags     (alloc_tags),
    .free_mask      (free_mask),
    .recover_en     (recover_en),
    .arch_used_mask (arch_used_mask),
    .free_count     (free_count),
    .double_free    (double_free)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alloc_req = '0; free_mask = '0; recover_en = 1'b0; arch_used_mask = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Compare process: evaluated at the falling edge, then the model steps to the next state.
  always @(negedge clock) begin
    bit            taken [PHYS];
    bit            denied;
    bit            found;
    logic [N-1:0]  eg;
    logic [N-1:0][PRW-1:0] et;
    int            cnt;
    if (reset) begin
      for (int i = 0; i < PHYS; i++) mfree[i] = (i >= ARCH);
      mdbl = 1'b0;
      check("grant_in_reset", 64'(alloc_grant), 64'd0);
      check("count_in_reset", 64'(free_count), 64'(PHYS - ARCH));
      check("dbl_in_reset", 64'(double_free), 64'd0);
    end else begin
      cnt = 0;
      for (int i = 0; i < PHYS; i++) cnt += int'(mfree[i]);
      check("model_count", 64'(free_count), 64'(cnt));
      check("model_dbl", 64'(double_free), 64'(mdbl));

      eg = '0; et = '0; denied = 1'b0;
      for (int i = 0; i < PHYS; i++) taken[i] = 1'b0;
      if (!recover_en) begin
        for (int w = N - 1; w >= 0; w--) begin
          if (alloc_req[w] && !denied) begin
            found = 1'b0;
            for (int i = 1; i < PHYS; i++) begin
              if (!found && mfree[i] && !taken[i]) begin
                found = 1'b1; taken[i] = 1'b1; eg[w] = 1'b1; et[w] = PRW'(i);
              end
            end
            if (!found) denied = 1'b1;
          end
        end
      end
      check("model_grant", 64'(alloc_grant), 64'(eg));
      check("model_tags", 64'(alloc_tags), 64'(et));

      if (recover_en) begin
        for (int i = 0; i < PHYS; i++) mfree[i] = (i != 0) && !arch_used_mask[i];
      end else begin
        for (int i = 1; i < PHYS; i++) if (free_mask[i] && mfree[i]) mdbl = 1'b1;
        for (int i = 1; i < PHYS; i++) if (taken[i]) mfree[i] = 1'b0;
        for (int i = 1; i < PHYS; i++) if (free_mask[i]) mfree[i] = 1'b1;
      end
    end
  end

  initial begin
    // Reset state and the first full allocation.
    alloc_req = 3'b111;
    tick();
    #1 check("grant_held_by_reset", 64'(alloc_grant), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("reset_count", 64'(free_count), 64'd32);
    check("reset_dbl", 64'(double_free), 64'd0);
    check("first_grant", 64'(alloc_grant), 64'b111);
    check("first_tag2", 64'(alloc_tags[2]), 64'd32);
    check("first_tag1", 64'(alloc_tags[1]), 64'd33);
    check("first_tag0", 64'(alloc_tags[0]), 64'd34);
    tick();
    alloc_req = '0;
    check("count_after_3", 64'(free_count), 64'd29);

    // Partial request: middle lane idle.
    do_reset();
    alloc_req = 3'b101;
    #1;
    check("partial_grant", 64'(alloc_grant), 64'b101);
    check("partial_tag2", 64'(alloc_tags[2]), 64'd32);
    check("partial_tag1", 64'(alloc_tags[1]), 64'd0);
    check("partial_tag0", 64'(alloc_tags[0]), 64'd33);
    tick();
    alloc_req = '0;
    check("partial_count", 64'(free_count), 64'd30);

    // Exhaust, then a single free becomes grantable one cycle later.
    do_reset();
    alloc_req = 3'b111;
    for (int c = 0; c < 20 && free_count != 0; c++) tick();
    check("drained_count", 64'(free_count), 64'd0);
    #1 check("empty_grant", 64'(alloc_grant), 64'd0);
    free_mask = 64'(1) << 40;
    #1 check("no_bypass_grant", 64'(alloc_grant), 64'd0);
    tick();
    free_mask = '0;
    alloc_req = 3'b100;
    #1;
    check("freed_grant", 64'(alloc_grant), 64'b100);
    check("freed_tag2", 64'(alloc_tags[2]), 64'd40);
    tick();
    alloc_req = '0;
    check("drained_again", 64'(free_count), 64'd0);

    // Freeing PR0 is ignored; freeing an already-free PR is sticky.
    do_reset();
    free_mask = 64'd1;
    tick();
    free_mask = '0;
    check("pr0_free_dbl", 64'(double_free), 64'd0);
    check("pr0_free_count", 64'(free_count), 64'd32);
    free_mask = 64'(1) << 50;
    tick();
    free_mask = '0;
    check("dbl_set", 64'(double_free), 64'd1);
    check("dbl_count", 64'(free_count), 64'd32);
    repeat (10) tick();
    check("dbl_sticky", 64'(double_free), 64'd1);

    // Recovery overrides allocation in its cycle.
    do_reset();
    alloc_req = 3'b111;
    repeat (3) tick();
    check("pre_recover_count", 64'(free_count), 64'd23);
    recover_en = 1'b1;
    arch_used_mask = 64'h0000_0008_FFFF_FFFF;
    #1 check("recover_grant", 64'(alloc_grant), 64'd0);
    tick();
    recover_en = 1'b0;
    arch_used_mask = '0;
    alloc_req = 3'b100;
    #1;
    check("recover_count", 64'(free_count), 64'd31);
    check("recover_first_tag", 64'(alloc_tags[2]), 64'd32);
    tick();

    // Asynchronous reset between edges.
    alloc_req = 3'b111;
    #1 check("pre_reset_grant", 64'(alloc_grant), 64'b111);
    reset = 1'b1;
    #1;
    check("async_grant_drop", 64'(alloc_grant), 64'd0);
    check("async_count", 64'(free_count), 64'd32);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_reset_count", 64'(free_count), 64'd32);
    check("post_reset_tag2", 64'(alloc_tags[2]), 64'd32);
    check("post_reset_tag0", 64'(alloc_tags[0]), 64'd34);

    // Randomized traffic; the compare process checks every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      alloc_req = N'($urandom_range(0, 7));
      arch_used_mask = {$urandom, $urandom};
      free_mask = '0;
      recover_en = ($urandom_range(0, 49) == 0);
      if (!recover_en) begin
        for (int i = 1; i < PHYS; i++)
          if (!mfree[i] && $urandom_range(0, 3) == 0) free_mask[i] = 1'b1;
        if ($urandom_range(0, 299) == 0) free_mask[$urandom_range(0, PHYS - 1)] = 1'b1;
      end
      tick();
    end
    alloc_req = '0; free_mask = '0; recover_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
